// File: rtl/rng_lfsr.sv
// rng_lfsr: 8-bit maximal-length Fibonacci LFSR (x^8+x^6+x^5+x^4+1) whose
// advancement is gated by a synchronised run/hold switch.
// The switch is asynchronous to clk, so it passes through a flop chain before
// it may enable the LFSR. The output is the state register itself, so no
// combinational path exists from any input to out.

module rng_lfsr #(
  parameter logic [7:0] SEED        = 8'h01,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       switch,
  output logic [7:0] out
);

  // An all-zero seed would lock the LFSR, so substitute 8'h01 in that case.
  localparam logic [7:0] RESET_VALUE = (SEED == 8'h00) ? 8'h01 : SEED;

  // Fewer than two synchroniser flops is not safe against metastability.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync;
  logic              sw_s;
  logic              fb;
  logic [7:0]        state;

  // Shift the asynchronous switch through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[STAGES-2:0], switch};
    end
  end

  assign sw_s = sync[STAGES-1];

  // Feedback taps for x^8+x^6+x^5+x^4+1 in left-shifting Fibonacci form.
  assign fb = state[7] ^ state[5] ^ state[4] ^ state[3];

  // Advance the LFSR while running; an all-zero state is forced out of lockup regardless of the switch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_VALUE;
    end else if (state == 8'h00) begin
      state <= 8'h01;
    end else if (sw_s) begin
      state <= {state[6:0], fb};
    end
  end

  assign out = state;

endmodule

// File: tb/tb_rng_lfsr.sv
// tb_rng_lfsr: self-checking bench for rng_lfsr. Three instances share the
// stimulus: the default seed, SEED=0 (must behave like seed 01), and SEED=B4.
// A reference model predicts every instance from the written rules: the
// switch is seen after a fixed number of edges, and each enabled edge
// applies the polynomial step using plain arithmetic.

module tb_rng_lfsr;

  localparam int SYNC = 2;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       switch = 1'b0;
  logic [7:0] out0;
  logic [7:0] outZero;
  logic [7:0] outB4;

  int testCount = 0;
  int failCount = 0;

  rng_lfsr #(.SEED(8'h01), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .switch(switch), .out(out0)
  );

  rng_lfsr #(.SEED(8'h00), .SYNC_STAGES(SYNC)) dutZero (
    .clk(clk), .rst(rst), .switch(switch), .out(outZero)
  );

  rng_lfsr #(.SEED(8'hB4), .SYNC_STAGES(SYNC)) dutB4 (
    .clk(clk), .rst(rst), .switch(switch), .out(outB4)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // One step of the polynomial: feedback is the parity of taps 7,5,4,3 (mask B8).
  function automatic logic [7:0] lfsrNext(input logic [7:0] v);
    int fbBit;
    int nextVal;
    fbBit   = $countones(v & 8'hB8) % 2;
    nextVal = ((int'(v) * 2) % 256) + fbBit;
    return nextVal[7:0];
  endfunction

  // Reference model: the switch value sampled at an edge enables the step SYNC edges later.
  logic [7:0] resetVal [3] = '{8'h01, 8'h01, 8'hB4};
  logic [7:0] mstate   [3] = '{8'h01, 8'h01, 8'hB4};
  int         swq [$]      = '{0, 0};

  // Track the expected state of each instance at every edge or reset.
  always @(posedge clk or posedge rst) begin
    int adv;
    if (rst) begin
      for (int i = 0; i < 3; i++) mstate[i] = resetVal[i];
      swq.delete();
      for (int i = 0; i < SYNC; i++) swq.push_back(0);
    end else begin
      adv = swq.pop_front();
      swq.push_back(int'(switch));
      if (adv != 0) begin
        for (int i = 0; i < 3; i++) mstate[i] = lfsrNext(mstate[i]);
      end
    end
  end

  typedef struct {
    logic       sw;
    logic [7:0] expMain;
    logic [7:0] expB4;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge: drive switch, cross one rising edge, return at the next falling edge.
  task automatic applyStimulus(input logic sw);
    switch = sw;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic compareModel(input string name);
    checkOutput({name, "/seed01"}, out0,    mstate[0]);
    checkOutput({name, "/seed00"}, outZero, mstate[1]);
    checkOutput({name, "/seedB4"}, outB4,   mstate[2]);
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, "/seed01"}, out0,    8'h01);
    checkOutput({name, "/seed00"}, outZero, 8'h01);
    checkOutput({name, "/seedB4"}, outB4,   8'hB4);
  endtask

  initial begin
    logic [7:0] base;
    logic [7:0] frozenExp;
    logic [7:0] wrapExp;
    logic [7:0] v;
    int         distinct;
    int         zeroHits;
    bit         seen [256];

    // Start-latency table: switch rises before edge k, values after edges k..k+6.
    vecs[0] = '{1'b1, 8'h01, 8'hB4};
    vecs[1] = '{1'b1, 8'h01, 8'hB4};
    vecs[2] = '{1'b1, 8'h02, 8'h69};
    vecs[3] = '{1'b1, 8'h04, 8'hD2};
    vecs[4] = '{1'b1, 8'h08, 8'hA4};
    vecs[5] = '{1'b1, 8'h11, 8'h48};
    vecs[6] = '{1'b1, 8'h23, 8'h91};

    // Reset held for 10 cycles with the switch off.
    repeat (10) begin
      @(negedge clk);
      checkResetValues("resetHold");
    end
    rst = 1'b0;

    // Idle after release: nothing may move.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0);
      checkResetValues("idleAfterReset");
    end

    // Table-driven start latency.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].sw);
      checkOutput($sformatf("startMain[%0d]", i), out0,    vecs[i].expMain);
      checkOutput($sformatf("startZero[%0d]", i), outZero, vecs[i].expMain);
      checkOutput($sformatf("startB4[%0d]", i),   outB4,   vecs[i].expB4);
    end

    // Five more advances to reach ten, then drop the switch.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1);
      compareModel("runToTen");
    end
    base      = mstate[0];
    frozenExp = lfsrNext(lfsrNext(base));
    applyStimulus(1'b0);
    checkOutput("holdLatency1", out0, lfsrNext(base));
    applyStimulus(1'b0);
    checkOutput("holdLatency2", out0, frozenExp);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0);
      checkOutput("holdFrozen", out0, frozenExp);
    end

    // Resume: two more frozen edges, then the very next value in sequence.
    applyStimulus(1'b1);
    checkOutput("resume0", out0, frozenExp);
    applyStimulus(1'b1);
    checkOutput("resume1", out0, frozenExp);
    applyStimulus(1'b1);
    checkOutput("resume2", out0, lfsrNext(frozenExp));
    compareModel("resume");

    // Random switch activity, including toggles faster than the synchroniser.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)));
      compareModel("random");
    end

    // Period and coverage over 255 advances, then the 256th must equal the first.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1);
      compareModel("periodLeadIn");
    end
    wrapExp = mstate[0];
    for (int i = 0; i < 256; i++) wrapExp = lfsrNext(wrapExp);
    base     = mstate[0];
    distinct = 0;
    zeroHits = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1);
      v = out0;
      if (i < 255) begin
        if (!seen[v]) begin
          seen[v] = 1'b1;
          distinct++;
        end
        if (v == 8'h00) zeroHits++;
      end
    end
    checkOutput("periodDistinct", distinct, 255);
    checkOutput("periodZeroSeen", zeroHits, 0);
    checkOutput("periodWrap", out0, wrapExp);
    checkOutput("periodWrapIsFirst", out0, lfsrNext(base));
    compareModel("periodEnd");

    // Fifty advances, then an asynchronous mid-cycle reset pulse.
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b1);
      compareModel("preReset");
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkResetValues("midResetImmediate");
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    checkResetValues("midResetReleased");
    applyStimulus(1'b1);
    checkOutput("postReset1", out0, 8'h01);
    applyStimulus(1'b1);
    checkOutput("postReset2", out0, 8'h01);
    applyStimulus(1'b1);
    checkOutput("postReset3", out0, 8'h02);
    checkOutput("postReset3B4", outB4, 8'h69);
    compareModel("postReset");

    // Stop advancing, then plant an all-zero state and expect recovery to 01 while holding.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0);
      compareModel("preLockup");
    end
    checkOutput("lockupPre", out0, 8'h08);
    force dut.state = 8'h00;
    #1 release dut.state;
    applyStimulus(1'b0);
    checkOutput("lockupRecover", out0, 8'h01);
    applyStimulus(1'b0);
    checkOutput("lockupHold", out0, 8'h01);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
